// File: rtl/easyaxi_slv_rd_pkg.sv
// EasyAXI shared channel widths/encodings plus types for the read responder.
// Optional build macro: EASYAXI_SLV_RD_DELAY_EN adds a WAIT state ahead of
// every burst's first beat.
`ifndef EASYAXI_DEFINE_V
`define EASYAXI_DEFINE_V
`define AXI_ID_W        4
`define AXI_ADDR_W      32
`define AXI_LEN_W       8
`define AXI_SIZE_W      3
`define AXI_BURST_W     2
`define AXI_DATA_W      32
`define AXI_RESP_W      2
`define AXI_BURST_FIXED 2'b00
`define AXI_BURST_INCR  2'b01
`define AXI_BURST_WRAP  2'b10
`define AXI_RESP_OK     2'b00
`define AXI_RESP_SLVERR 2'b10
`define AXI_SIZE_4B     3'b010
`endif

package easyaxi_slv_rd_pkg;

  localparam int AW = `AXI_ADDR_W;
  localparam int LW = `AXI_LEN_W;
  localparam int SW = `AXI_SIZE_W;
  localparam int BW = `AXI_BURST_W;

  // One queued AR request; also the live burst context while beats go out.
  typedef struct packed {
    logic [`AXI_ID_W-1:0]    id;
    logic [`AXI_ADDR_W-1:0]  addr;
    logic [`AXI_LEN_W-1:0]   len;
    logic [`AXI_SIZE_W-1:0]  size;
    logic [`AXI_BURST_W-1:0] burst;
  } ar_req_t;

  localparam int AR_REQ_W = $bits(ar_req_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1
`ifdef EASYAXI_SLV_RD_DELAY_EN
    , ST_WAIT = 2'd2
`endif
  } rd_state_e;

  // Address of the following beat. WRAP with an illegal length falls back
  // to INCR; any non-FIXED/WRAP encoding also steps like INCR.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                              input logic [LW-1:0] len,
                                              input logic [SW-1:0] size,
                                              input logic [BW-1:0] burst);
    logic [AW-1:0] step, sum, win, res;
    logic          wrap_ok;
    step    = AW'(1) << size;
    sum     = a + step;
    win     = (AW'(len) + AW'(1)) << size;
    wrap_ok = (len == LW'(1)) || (len == LW'(3)) || (len == LW'(7)) || (len == LW'(15));
    res     = sum;
    if (burst == `AXI_BURST_FIXED)
      res = a;
    else if (burst == `AXI_BURST_WRAP && wrap_ok)
      res = (a & ~(win - AW'(1))) | (sum & (win - AW'(1)));
    return res;
  endfunction

endpackage

// File: rtl/easyaxi_slv_fifo.sv
// Generic synchronous FIFO; push is ignored when full, pop when empty.
module easyaxi_slv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers and occupancy; simultaneous push/pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/easyaxi_slv_rd.sv
// EasyAXI read responder: queues AR requests, returns in-order R bursts whose
// data is the beat address. Optional macro EASYAXI_SLV_RD_DELAY_EN inserts
// RD_DLY wait cycles before the first beat of each burst.
module easyaxi_slv_rd
  import easyaxi_slv_rd_pkg::*;
#(
  parameter int                     OST_DEPTH  = 4,
  parameter logic [`AXI_ADDR_W-1:0] ADDR_LIMIT = 32'h0000_1000,
  parameter int                     RD_DLY     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     axi_slv_arvalid,
  output logic                     axi_slv_arready,
  input  logic [`AXI_ID_W-1:0]     axi_slv_arid,
  input  logic [`AXI_ADDR_W-1:0]   axi_slv_araddr,
  input  logic [`AXI_LEN_W-1:0]    axi_slv_arlen,
  input  logic [`AXI_SIZE_W-1:0]   axi_slv_arsize,
  input  logic [`AXI_BURST_W-1:0]  axi_slv_arburst,
  output logic                     axi_slv_rvalid,
  input  logic                     axi_slv_rready,
  output logic [`AXI_ID_W-1:0]     axi_slv_rid,
  output logic [`AXI_DATA_W-1:0]   axi_slv_rdata,
  output logic [`AXI_RESP_W-1:0]   axi_slv_rresp,
  output logic                     axi_slv_rlast
);

`ifdef EASYAXI_SLV_RD_DELAY_EN
  localparam rd_state_e  POP_ST = (RD_DLY == 0) ? ST_DATA : ST_WAIT;
  localparam logic [7:0] DLY_LD = (RD_DLY > 0) ? 8'(RD_DLY - 1) : 8'd0;
  logic [7:0] dly_q, dly_d;
`else
  localparam rd_state_e  POP_ST = ST_DATA;
`endif

  rd_state_e             state_q, state_d;
  ar_req_t               req_q, req_d, q_head, q_in;
  logic [`AXI_LEN_W-1:0] beat_q, beat_d;
  logic                  q_full, q_empty, q_pop, ar_hs, r_hs, is_last;
  logic [$clog2(OST_DEPTH):0] q_cnt;

  assign axi_slv_arready = ~q_full;
  assign ar_hs = axi_slv_arvalid & axi_slv_arready;
  assign q_in  = '{id: axi_slv_arid, addr: axi_slv_araddr, len: axi_slv_arlen,
                   size: axi_slv_arsize, burst: axi_slv_arburst};

  easyaxi_slv_fifo #(.WIDTH(AR_REQ_W), .DEPTH(OST_DEPTH)) u_ar_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ar_hs),
    .data_i  (q_in),
    .pop_i   (q_pop),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_cnt)
  );

  assign axi_slv_rvalid = (state_q == ST_DATA);
  assign is_last        = (beat_q == req_q.len);
  assign r_hs           = axi_slv_rvalid & axi_slv_rready;
  assign axi_slv_rlast  = axi_slv_rvalid & is_last;
  assign axi_slv_rid    = req_q.id;
  assign axi_slv_rdata  = `AXI_DATA_W'(req_q.addr);
  assign axi_slv_rresp  = (req_q.addr >= ADDR_LIMIT || req_q.burst == 2'b11)
                          ? `AXI_RESP_SLVERR : `AXI_RESP_OK;

  // Next state: pop on idle or on the last beat (zero-bubble), else step beats.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    beat_d  = beat_q;
    q_pop   = 1'b0;
`ifdef EASYAXI_SLV_RD_DELAY_EN
    dly_d   = dly_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          q_pop   = 1'b1;
          req_d   = q_head;
          beat_d  = '0;
          state_d = POP_ST;
`ifdef EASYAXI_SLV_RD_DELAY_EN
          dly_d   = DLY_LD;
`endif
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          if (is_last) begin
            if (!q_empty) begin
              q_pop   = 1'b1;
              req_d   = q_head;
              beat_d  = '0;
              state_d = POP_ST;
`ifdef EASYAXI_SLV_RD_DELAY_EN
              dly_d   = DLY_LD;
`endif
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_d     = beat_q + `AXI_LEN_W'(1);
            req_d.addr = next_addr(req_q.addr, req_q.len, req_q.size, req_q.burst);
          end
        end
      end
`ifdef EASYAXI_SLV_RD_DELAY_EN
      ST_WAIT: begin
        if (dly_q == 8'd0) state_d = ST_DATA;
        else               dly_d   = dly_q - 8'd1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst context registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      beat_q  <= beat_d;
    end
  end

`ifdef EASYAXI_SLV_RD_DELAY_EN
  // First-beat delay counter.
  always_ff @(posedge clk) begin
    if (rst) dly_q <= 8'd0;
    else     dly_q <= dly_d;
  end
`endif

endmodule

// File: tb/tb_easyaxi_slv_rd.sv
// Scoreboard bench for easyaxi_slv_rd: AR handshakes feed a burst model that
// queues expected beats; a negedge monitor pops and compares every R beat.
module tb_easyaxi_slv_rd;

  localparam logic [31:0] LIMIT = 32'h0000_1000;
`ifdef EASYAXI_SLV_RD_DELAY_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        arvalid = 1'b0, arready;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        rvalid, rready = 1'b0, rlast;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  always #5 clk = ~clk;

  easyaxi_slv_rd dut (
    .clk(clk), .rst(rst),
    .axi_slv_arvalid(arvalid), .axi_slv_arready(arready), .axi_slv_arid(arid),
    .axi_slv_araddr(araddr), .axi_slv_arlen(arlen), .axi_slv_arsize(arsize),
    .axi_slv_arburst(arburst), .axi_slv_rvalid(rvalid), .axi_slv_rready(rready),
    .axi_slv_rid(rid), .axi_slv_rdata(rdata), .axi_slv_rresp(rresp),
    .axi_slv_rlast(rlast)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    bit          chk_data;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0, checks = 0, cyc = 0;
  int    rr_mode = 1;          // 0 low, 1 high, 2 toggle, 3 random
  int    last_rlast_cyc = 0;
  bit    chk_bubble = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Burst model from the addressing rules, one entry per expected beat.
  task automatic model_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] b);
    logic [31:0] bytes, win, base, addr;
    int nb;
    bit wrap;
    beat_t e;
    nb    = int'(len) + 1;
    bytes = 32'd1 << sz;
    win   = bytes * nb;
    base  = (a / win) * win;
    wrap  = (b == 2'b10) && (nb == 2 || nb == 4 || nb == 8 || nb == 16);
    for (int i = 0; i < nb; i++) begin
      if (b == 2'b00)  addr = a;
      else if (wrap)   addr = base + ((a - base + bytes * i) % win);
      else             addr = a + bytes * i;
      e.id       = id;
      e.data     = addr;
      e.resp     = (b == 2'b11 || addr >= LIMIT) ? 2'b10 : 2'b00;
      e.last     = (i == nb - 1);
      e.chk_data = (b != 2'b11);
      exp_q.push_back(e);
    end
  endtask

  // R-ready pattern generator.
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       rready = 1'b0;
      1:       rready = 1'b1;
      2:       rready = ~rready;
      default: rready = 1'($urandom % 2);
    endcase
  end

  // Monitor: AR handshakes feed the model, R beats are scored.
  always @(negedge clk) begin : mon
    static bit          stall_v = 1'b0, prev_last = 1'b0;
    static logic [38:0] held = '0;
    beat_t e;
    if (rst) begin
      stall_v   = 1'b0;
      prev_last = 1'b0;
    end else begin
      if (chk_bubble && prev_last && exp_q.size() > 0) chk("no_bubble", rvalid, 1'b1);
      prev_last = 1'b0;
      if (stall_v && rvalid) chk("stall_stable", {rid, rdata, rresp, rlast}, held);
      if (arvalid && arready) model_ar(arid, araddr, arlen, arsize, arburst);
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", rvalid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("rid", rid, e.id);
          if (e.chk_data) chk("rdata", rdata, e.data);
          chk("rresp", rresp, e.resp);
          chk("rlast", rlast, e.last);
        end
        if (rlast) begin
          last_rlast_cyc = cyc;
          prev_last      = 1'b1;
        end
      end
      stall_v = rvalid && !rready;
      held    = {rid, rdata, rresp, rlast};
    end
  end

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] b, output int hs);
    int n;
    arvalid = 1'b1; arid = id; araddr = a; arlen = len; arsize = sz; arburst = b;
    @(negedge clk);
    n = 0;
    while (!arready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!arready) begin
      chk("ar_timeout", 1'b1, 1'b0);
      hs = -1;
    end else begin
      hs = cyc;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rvalid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || rvalid) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int hs, n, hs6, l1;
    logic [1:0] b;
    logic [7:0] len;
    logic [31:0] a;
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rid", rid, 4'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_arready", arready, 1'b1);
    @(posedge clk); #1;

    // Single INCR with first-beat latency
    rr_mode = 1;
    send_ar(4'd1, 32'h10, 8'd3, 3'd2, 2'b01, hs);
    n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("first_latency", cyc - hs, LAT);
    drain();

    // WRAP under toggling backpressure
    rr_mode = 2;
    send_ar(4'd2, 32'h38, 8'd3, 3'd2, 2'b10, hs);
    drain();

    // Queue full: OST_DEPTH entries sit behind the burst being returned
    rr_mode = 0;
    @(posedge clk); #1;
    chk_bubble = 1'b1;
    for (int i = 1; i <= 5; i++) send_ar(4'(i), 32'h100 * i, 8'd1, 3'd2, 2'b01, hs);
    @(negedge clk);
    chk("full_arready", arready, 1'b0);
    fork
      send_ar(4'd6, 32'h600, 8'd1, 3'd2, 2'b01, hs6);
      begin
        repeat (4) @(negedge clk);
        chk("full_hold", arready, 1'b0);
        rr_mode = 1;
      end
    join
    l1 = last_rlast_cyc;
    chk("full_reaccept", hs6, l1 + 1);
    drain();
    chk_bubble = 1'b0;

    // Errors: crossing the limit, then reserved burst type
    send_ar(4'd7, 32'hFFC, 8'd1, 3'd2, 2'b01, hs);
    drain();
    send_ar(4'd3, 32'h20, 8'd2, 3'd2, 2'b11, hs);
    drain();

    // Reset mid-burst
    send_ar(4'd5, 32'h200, 8'd7, 3'd2, 2'b01, hs);
    n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_rvalid", rvalid, 1'b0);
    chk("rst_mid_rlast", rlast, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_arready", arready, 1'b1);
    @(posedge clk); #1;
    send_ar(4'd6, 32'h40, 8'd2, 3'd2, 2'b01, hs);
    drain();

    // Randomized mix
    rr_mode = 3;
    for (int i = 0; i < 30; i++) begin
      b = 2'($urandom % 4);
      if (b == 2'b10 && ($urandom % 4) != 0) begin
        case ($urandom % 4)
          0: len = 8'd1;
          1: len = 8'd3;
          2: len = 8'd7;
          default: len = 8'd15;
        endcase
      end else begin
        len = 8'($urandom % 9);
      end
      case ($urandom % 3)
        0: a = 32'hFE0 + 32'($urandom % 64);
        1: a = 32'hFFFF_FFE0 + 32'($urandom % 32);
        default: a = 32'($urandom % 32'h1100);
      endcase
      send_ar(4'($urandom), a, len, 3'($urandom % 3), b, hs);
      if (($urandom % 4) == 0) repeat ($urandom % 6) @(posedge clk);
      #1;
    end
    drain();
    chk("queue_empty_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
